// File: rtl/io_port_pkg.sv
// Shared constants for the memory-mapped I/O port responder: register word
// offsets, STATUS bit positions, and reset/base defaults.
package io_port_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0100;
  localparam logic [31:0] CMP_RESET         = 32'hFFFF_FFFF;

  // Word index within the 32-byte window (Address[4:2]).
  typedef enum logic [2:0] {
    REG_OUT    = 3'd0,
    REG_IN     = 3'd1,
    REG_STATUS = 3'd2,
    REG_IRQEN  = 3'd3,
    REG_TIMER  = 3'd4,
    REG_CMP    = 3'd5,
    REG_CTRL   = 3'd6,
    REG_RSVD   = 3'd7
  } reg_offset_e;

  localparam int STATUS_CHG = 0;
  localparam int STATUS_TMR = 1;

endpackage

// File: rtl/io_input_sync.sv
// Two-flop synchronizer for the external input port, plus a previous-value
// flop so a change on the synchronized value can be flagged.
module io_input_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic             changed
);

  logic [WIDTH-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync    = s2;
  assign changed = (s2 != s3);

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: OUT/IN/STATUS/IRQEN registers in a 32-byte window.
// The TIMER/CMP/CTRL compare timer is built only when IO_PORT_TIMER_EN is defined.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  reg_offset_e         offset;
  logic                wr, rd;
  logic [IN_WIDTH-1:0] in_sync;
  logic                in_changed;
  logic [1:0]          status, status_set, status_clr, irqen;
  logic                tmr_match;
  logic [31:0]         reg_rdata;
  logic                unused_addr;

  assign Hit         = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset      = reg_offset_e'(Address[4:2]);
  assign wr          = MemWrite & Hit;
  assign rd          = MemRead & Hit;
  assign unused_addr = ^Address[1:0];

  io_input_sync #(.WIDTH(IN_WIDTH)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .din     (PortIn),
    .sync    (in_sync),
    .changed (in_changed)
  );

`ifdef IO_PORT_TIMER_EN
  localparam logic [1:0] IRQEN_MASK = 2'b11;

  logic [31:0] timer, cmp;
  logic        ten;

  // Match uses the current count, so a CMP write only affects later cycles.
  assign tmr_match = ten & (timer == cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
      cmp   <= CMP_RESET;
      ten   <= 1'b0;
    end else begin
      if (wr && offset == REG_TIMER) timer <= WriteData;
      else if (ten)                  timer <= timer + 32'd1;
      if (wr && offset == REG_CMP)   cmp   <= WriteData;
      if (wr && offset == REG_CTRL)  ten   <= WriteData[0];
    end
  end
`else
  localparam logic [1:0] IRQEN_MASK = 2'b01;
  assign tmr_match = 1'b0;
`endif

  always_comb begin
    status_set             = '0;
    status_set[STATUS_CHG] = in_changed;
    status_set[STATUS_TMR] = tmr_match;
    status_clr             = (wr && offset == REG_STATUS) ? WriteData[1:0] : 2'b00;
  end

  // Hardware set takes priority over a simultaneous write-one-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut <= '0;
      status  <= '0;
      irqen   <= '0;
      Irq     <= 1'b0;
    end else begin
      if (wr && offset == REG_OUT)   PortOut <= WriteData;
      if (wr && offset == REG_IRQEN) irqen   <= WriteData[1:0] & IRQEN_MASK;
      status <= (status & ~status_clr) | status_set;
      Irq    <= |(status & irqen);
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (offset)
      REG_OUT:    reg_rdata = PortOut;
      REG_IN:     reg_rdata = 32'(in_sync);
      REG_STATUS: reg_rdata = {30'd0, status};
      REG_IRQEN:  reg_rdata = {30'd0, irqen};
`ifdef IO_PORT_TIMER_EN
      REG_TIMER:  reg_rdata = timer;
      REG_CMP:    reg_rdata = cmp;
      REG_CTRL:   reg_rdata = {31'd0, ten};
`endif
      default:    reg_rdata = '0;
    endcase
  end

  assign ReadData = rd ? reg_rdata : '0;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed self-checking bench for io_port_responder; timer steps are
// compiled in only when IO_PORT_TIMER_EN is defined.
module tb_io_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0100;
`ifdef IO_PORT_TIMER_EN
  localparam logic [31:0] CMP_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] IRQEN_RD = 32'd3;
`else
  localparam logic [31:0] CMP_RST  = 32'd0;
  localparam logic [31:0] IRQEN_RD = 32'd1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, write_data, read_data, port_out;
  logic        mem_write, mem_read, hit, irq;
  logic [7:0]  port_in;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  io_port_responder dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (address),
    .WriteData (write_data),
    .MemWrite  (mem_write),
    .MemRead   (mem_read),
    .ReadData  (read_data),
    .Hit       (hit),
    .PortIn    (port_in),
    .PortOut   (port_out),
    .Irq       (irq)
  );

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic we, input logic re);
    address    = addr;
    write_data = data;
    mem_write  = we;
    mem_read   = re;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, data, 1'b1, 1'b0);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic checkRead(input string tag, input logic [4:0] off,
                           input logic [31:0] expected);
    applyStimulus(BASE + {27'd0, off}, 32'd0, 1'b0, 1'b1);
    #1;
    checkOutput(tag, read_data, expected);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    port_in = 8'h00;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_portout", port_out, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    checkRead("rst_out", 5'h00, 32'd0);
    checkRead("rst_status", 5'h08, 32'd0);
    checkRead("rst_cmp", 5'h14, CMP_RST);
    checkOutput("rst_irq2", {31'd0, irq}, 32'd0);

    store(BASE + 32'h00, 32'hA5A5_0001);
    checkOutput("out_write", port_out, 32'hA5A5_0001);
    checkRead("out_read", 5'h00, 32'hA5A5_0001);

    applyStimulus(BASE + 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1);
    #1;
    checkOutput("miss_hit", {31'd0, hit}, 32'd0);
    checkOutput("miss_rdata", read_data, 32'd0);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("miss_portout", port_out, 32'hA5A5_0001);

    applyStimulus(BASE, 32'h0000_1234, 1'b1, 1'b1);
    #1;
    checkOutput("rw_hit", {31'd0, hit}, 32'd1);
    checkOutput("rw_prewrite", read_data, 32'hA5A5_0001);
    tick();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("rw_portout", port_out, 32'h0000_1234);

    store(BASE + 32'h1C, 32'hFFFF_FFFF);
    checkRead("rsvd_read", 5'h1C, 32'd0);
    checkOutput("rsvd_portout", port_out, 32'h0000_1234);

    store(BASE + 32'h0C, 32'hFFFF_FFFF);
    checkRead("irqen_read", 5'h0C, IRQEN_RD);

    // input change: IN after 2 edges, CHG after 3, Irq after 4
    port_in = 8'h3C;
    tick();
    checkRead("in_edge1", 5'h04, 32'd0);
    tick();
    checkRead("in_edge2", 5'h04, 32'h0000_003C);
    checkRead("chg_edge2", 5'h08, 32'd0);
    tick();
    checkRead("chg_edge3", 5'h08, 32'd1);
    checkOutput("irq_edge3", {31'd0, irq}, 32'd0);
    tick();
    checkOutput("irq_edge4", {31'd0, irq}, 32'd1);
    store(BASE + 32'h08, 32'd1);
    checkRead("chg_w1c", 5'h08, 32'd0);
    checkOutput("irq_after_w1c", {31'd0, irq}, 32'd1);
    tick();
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);

`ifdef IO_PORT_TIMER_EN
    store(BASE + 32'h10, 32'd5);
    store(BASE + 32'h14, 32'd8);
    store(BASE + 32'h18, 32'd1);
    checkRead("tmr_start", 5'h10, 32'd5);
    tick();
    checkRead("tmr_6", 5'h10, 32'd6);
    tick();
    tick();
    checkRead("tmr_8", 5'h10, 32'd8);
    checkRead("tmr_nomatch_yet", 5'h08, 32'd0);
    tick();
    checkRead("tmr_set", 5'h08, 32'd2);
    tick();
    checkOutput("tmr_irq", {31'd0, irq}, 32'd1);
    store(BASE + 32'h14, 32'd12);
    tick();
    checkRead("tmr_12", 5'h10, 32'd12);
    store(BASE + 32'h08, 32'd2);
    checkRead("tmr_set_wins", 5'h08, 32'd2);
    store(BASE + 32'h08, 32'd2);
    checkRead("tmr_w1c", 5'h08, 32'd0);

    store(BASE + 32'h10, 32'hFFFF_FFFE);
    checkRead("wrap_load", 5'h10, 32'hFFFF_FFFE);
    tick();
    checkRead("wrap_ff", 5'h10, 32'hFFFF_FFFF);
    tick();
    checkRead("wrap_0", 5'h10, 32'd0);
    tick();
    checkRead("wrap_1", 5'h10, 32'd1);
    store(BASE + 32'h14, 32'd1);
    checkRead("cmp_no_retro", 5'h08, 32'd0);
    tick();
    checkRead("cmp_no_retro2", 5'h08, 32'd0);
`else
    store(BASE + 32'h10, 32'd5);
    store(BASE + 32'h18, 32'd1);
    checkRead("notmr_timer", 5'h10, 32'd0);
    checkRead("notmr_ctrl", 5'h18, 32'd0);
    tick();
    checkRead("notmr_status", 5'h08, 32'd0);
`endif

    // reset mid-operation, with the input partially synchronized
    port_in = 8'h55;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_portout", port_out, 32'd0);
    checkOutput("mid_rst_irq", {31'd0, irq}, 32'd0);
    checkRead("mid_rst_status", 5'h08, 32'd0);
    checkRead("mid_rst_timer", 5'h10, 32'd0);
    checkRead("mid_rst_cmp", 5'h14, CMP_RST);
    checkRead("mid_rst_irqen", 5'h0C, 32'd0);
    port_in = 8'h00;
    tick();
    reset = 1'b1;
    tick();
    checkRead("post_rst_in", 5'h04, 32'd0);
    checkRead("post_rst_chg", 5'h08, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_port_responder.md
# io_port_responder

Memory-mapped I/O responder on the processor's data-memory bus. It answers word loads and stores in a fixed address window, owns the registered `PortOut` value, and synchronizes the external 8-bit `PortIn`. It also provides a sticky input-change flag, a compare timer and an interrupt line. It sits beside `DataMemory` at the processor top. The top gates `DataMemory`'s `MemWrite` with `~Hit` and selects `ReadData` from this block when `Hit` is high.

## Interface
- `BASE_ADDR`, default `32'h1001_0100`: byte address of the 32-byte window. Must be 32-byte aligned.
- `IN_WIDTH`, default `8`: width of `PortIn`.
- `clk` in, 1: single clock. All state changes on the rising edge.
- `reset` in, 1: asynchronous, active-low. Asserted (0) clears all state immediately.
- `Address` in, 32: byte address from the ALU result.
- `WriteData` in, 32: store data (`ReadData2`).
- `MemWrite` in, 1: store strobe from the control unit.
- `MemRead` in, 1: load strobe from the control unit.
- `ReadData` out, 32: load data. Combinational.
- `Hit` out, 1: `Address[31:5] == BASE_ADDR[31:5]`. Combinational.
- `PortIn` in, `IN_WIDTH`: asynchronous external input.
- `PortOut` out, 32: registered output port.
- `Irq` out, 1: level interrupt, registered.

## Operation
- Register offsets are taken from `Address[4:2]`; `Address[1:0]` is ignored.
  - 0x00 `OUT` (RW): drives `PortOut`.
  - 0x04 `IN` (RO): synchronized input, zero-extended to 32 bits.
  - 0x08 `STATUS` (R/W1C): bit0 `CHG` = input changed; bit1 `TMR` = timer match.
  - 0x0C `IRQEN` (RW, bits[1:0]): interrupt enable mask per `STATUS` bit.
  - 0x10 `TIMER` (RW): current count.
  - 0x14 `CMP` (RW): compare value.
  - 0x18 `CTRL` (RW, bit0): `TEN`, timer enable.
  - 0x1C: reserved. Reads 0, writes ignored.
- Write: when `MemWrite & Hit` at the rising edge, the addressed register updates.
- Read: `ReadData` shows the addressed register while `MemRead & Hit`; otherwise it is 0.
- Input synchronization: `PortIn` passes through 2 flops (`s1`, `s2`). A third flop `s3` holds the previous `s2`.
  - `IN` reads `s2`.
  - `CHG` sets when `s2 != s3`.
- Timer:
  - When `TEN`=1, `TIMER` increments by 1 each cycle and wraps from `32'hFFFF_FFFF` to 0.
  - `TMR` sets in the cycle after `TIMER == CMP` while `TEN`=1.
- Irq: `Irq <= |(STATUS[1:0] & IRQEN[1:0])`.
- Boundary and priority rules:
  - A hardware set and a W1C of the same bit in the same cycle: the set wins, and the bit stays 1.
  - A `TIMER` write and an increment in the same cycle: the written value loads and no increment happens that cycle.
  - Writing `CMP` equal to the current `TIMER` does not retro-set `TMR`. The match is evaluated on the next cycle's count.
  - `MemRead` and `MemWrite` both high is not produced by the control unit. If it occurs, the write is performed and `ReadData` shows the pre-write value.
  - Reset asserted mid-operation clears all state at once, including partially synchronized input. `CHG` does not set on the first cycle after reset release, because `s2` and `s3` both start at 0.

## Timing
- Reset values:
  - `PortOut` = 0; `STATUS` = 0; `IRQEN` = 0; `TIMER` = 0; `CMP` = `32'hFFFF_FFFF`; `CTRL` = 0.
  - `s1`/`s2`/`s3` = 0; `Irq` = 0.
  - `ReadData` = 0 (no read).
- Read latency: 0 cycles (combinational, single-cycle core).
- Write latency: the register is visible the cycle after the store edge.
- `PortIn` to `IN`: 2 edges. `PortIn` to `CHG`: 3 edges. `CHG` to `Irq`: +1 edge.
- `TIMER == CMP` to `TMR`: 1 edge. `TMR` to `Irq`: +1 edge.

## Configuration
- Macro `IO_PORT_TIMER_EN`.
- Defined: the `TIMER`, `CMP` and `CTRL` registers and `STATUS.TMR` exist as described.
- Undefined:
  - Offsets 0x10–0x18 read 0 and writes are ignored.
  - `STATUS.TMR` and `IRQEN[1]` read 0.
  - No counter flops are synthesized.

## Structure
- Package `io_port_pkg`: offset constants, `STATUS` bit indices, `CMP` reset value and the default base address.
- Sub-module `io_input_sync`: 2-flop synchronizer plus previous-value flop. Outputs `sync` and a `changed` pulse. Async active-low reset.

## Test plan
- Reset, then load offsets 0x00, 0x08 and 0x14 → `ReadData` 0, 0 and `32'hFFFF_FFFF`; `Irq` = 0.
- Store `32'hA5A5_0001` to `BASE+0x00` → `PortOut` = `32'hA5A5_0001` the next cycle. A store to `BASE+0x40` leaves `Hit`=0 and `PortOut` unchanged.
- `PortIn` 0x00→0x3C → `IN` reads 0x3C after 2 edges and `CHG` = 1 after 3. With `IRQEN`=1, `Irq`=1 one edge later. A W1C of 1 to `STATUS` clears `CHG` and then `Irq`.
- Store `TIMER`=5, `CMP`=8, `CTRL`=1 → `TMR` sets 4 edges after `TEN` rises. A W1C in the same cycle as a new match leaves `TMR`=1.
- Store `TIMER` = `32'hFFFF_FFFE` with `TEN`=1 → counts `FFFF_FFFF`, 0, 1.
- Assert `reset` mid-count with `PortOut` ≠ 0 → all registers return to reset values asynchronously.
